// File: rtl/noc_pkg.sv
// Shared router definitions: arbiter FSM encoding and default port geometry.
// Imported by every router block so the constants stay consistent.
package noc_pkg;

    localparam int NOC_N_IN       = 5;
    localparam int NOC_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index width that stays legal for a single-input instance.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr, wrapping.
// Shared by the output arbiter and the crossbar allocator.
module rr_pick
    import noc_pkg::*;
#(
    parameter int N  = NOC_N_IN,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                win[cand] = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin arbiter for one router output port: grants a whole packet,
// forwards its flits through an output register and stalls on downstream full.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int N_IN       = NOC_N_IN,
    parameter int DATA_WIDTH = NOC_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_IN-1:0]            req,
    input  logic [N_IN-1:0]            in_tail,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data,
    input  logic                       out_full,
    output logic [N_IN-1:0]            grant,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int IW = idx_width(N_IN);

    arb_state_t            state, state_next;
    logic [IW-1:0]         owner, ptr, win_idx, ptr_after;
    logic [N_IN-1:0]       win;
    logic                  any, xfer, release_pkt;
    logic [DATA_WIDTH-1:0] owner_flit;

    rr_pick #(.N(N_IN), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any)         state_next = ST_BUSY;
            ST_BUSY: if (release_pkt) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Transfer uses the registered owner, which matches the grant the upstream FIFO pops on.
    always_comb begin
        owner_flit  = in_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        xfer        = (state == ST_BUSY) && req[owner] && !out_full;
        release_pkt = xfer && in_tail[owner];
        ptr_after   = (owner == IW'(N_IN - 1)) ? '0 : owner + 1'b1;
        busy        = (state == ST_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            ptr       <= '0;
            grant     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) out_data <= owner_flit;
            if (state == ST_IDLE && any) begin
                owner <= win_idx;
                grant <= win;
            end
            if (release_pkt) begin
                grant <= '0;
                ptr   <= ptr_after;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter: modelled input FIFOs feed the arbiter,
// monitors compare forwarded flits and grant owners against hand-ordered expectations.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int N  = 5;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          tail;
        int            hold;
    } flit_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    in_tail;
    logic [N*DW-1:0] in_data;
    logic            out_full;
    logic [N-1:0]    grant;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            busy;

    flit_t         src_q[N][$];
    logic [DW-1:0] exp_data[$];
    int            exp_grant[$];

    int checks = 0;
    int errors = 0;

    logic [N-1:0] pending     = '0;
    logic         stalled     = 1'b0;
    logic [N-1:0] stall_grant = '0;
    logic [N-1:0] prev_grant  = '0;

    noc_output_arbiter #(.N_IN(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_tail   (in_tail),
        .in_data   (in_data),
        .out_full  (out_full),
        .grant     (grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int outstanding();
        int total = exp_data.size() + exp_grant.size();
        for (int i = 0; i < N; i++) total += src_q[i].size();
        return total;
    endfunction

    // Input-controller model: present FIFO heads, pop on grant & req & ~out_full,
    // and raise out_full while a flit with a hold count is presented by the owner.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) src_q[i].delete();
            pending  = '0;
            stalled  = 1'b0;
            req      = '0;
            in_tail  = '0;
            in_data  = '0;
            out_full = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_no_valid", out_valid, 0);
                check("stall_grant_held", grant, stall_grant);
            end
            for (int i = 0; i < N; i++)
                if (pending[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            out_full = 1'b0;
            for (int i = 0; i < N; i++) begin
                req[i]           = 1'b0;
                in_tail[i]       = 1'b1;
                in_data[i*DW+:DW] = 8'hEE;
                if (src_q[i].size() > 0) begin
                    req[i]            = 1'b1;
                    in_tail[i]        = src_q[i][0].tail;
                    in_data[i*DW+:DW] = src_q[i][0].data;
                    if (grant[i] && src_q[i][0].hold > 0) begin
                        out_full         = 1'b1;
                        src_q[i][0].hold = src_q[i][0].hold - 1;
                    end
                end
            end
            stalled     = out_full;
            stall_grant = grant;
            pending     = grant & req & {N{~out_full}};
        end
    end

    // Monitor: every forwarded flit and every new grant is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_grant = '0;
        end else begin
            if (out_valid) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_flit: got 0x%0h expected none at %0t", out_data, $time);
                end else begin
                    check("flit", out_data, exp_data.pop_front());
                end
            end
            if (grant != prev_grant && grant != '0) begin
                check("grant_onehot", $countones(grant), 1);
                check("grant_gap", prev_grant, 0);
                if (exp_grant.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_grant: got 0x%0h expected none at %0t", grant, $time);
                end else begin
                    check("grant_owner", onehot_idx(grant), exp_grant.pop_front());
                end
            end
            prev_grant = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int src, input logic [DW-1:0] data, input logic tail, input int hold);
        flit_t f;
        f.data = data;
        f.tail = tail;
        f.hold = hold;
        src_q[src].push_back(f);
    endtask

    // Flits must be sent in the order they are expected on the output link.
    task automatic send(input int src, input logic [DW-1:0] data, input logic tail, input int hold);
        load(src, data, tail, hold);
        exp_data.push_back(data);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (outstanding() == 0) break;
            tick();
        end
        check({"drain_", name}, outstanding(), 0);
        tick();
        tick();
    endtask

    logic [N-1:0] gtrace[12] = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000,
                                 5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};

    initial begin
        rst_n    = 1'b1;
        req      = '0;
        in_tail  = '0;
        in_data  = '0;
        out_full = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle_grant", grant, 0);

        // Single requester, 3-flit packet from input 1.
        send(1, 8'hA1, 1'b0, 0);
        send(1, 8'hA2, 1'b0, 0);
        send(1, 8'hA3, 1'b1, 0);
        exp_grant.push_back(1);
        tick();
        check("t2_grant_c1", grant, 5'b00010);
        check("t2_busy_c1", busy, 1);
        check("t2_valid_c1", out_valid, 0);
        tick();
        check("t2_grant_c2", grant, 5'b00010);
        check("t2_valid_c2", out_valid, 1);
        tick();
        check("t2_grant_c3", grant, 5'b00010);
        check("t2_valid_c3", out_valid, 1);
        tick();
        check("t2_grant_rel", grant, 0);
        check("t2_busy_rel", busy, 0);
        check("t2_valid_c4", out_valid, 1);
        tick();
        check("t2_valid_c5", out_valid, 0);
        wait_drain("single", 30);

        // Backpressure on input 3's second flit; input 1 competes (ptr=2 favours 3).
        send(3, 8'hB1, 1'b0, 0);
        send(3, 8'hB2, 1'b0, 2);
        send(3, 8'hB3, 1'b1, 0);
        send(1, 8'h1F, 1'b1, 0);
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        wait_drain("backpressure", 40);
        send(3, 8'h3C, 1'b1, 0);
        exp_grant.push_back(3);
        wait_drain("ptr_to_4", 20);

        // Wraparound with ptr=4: input 0 wins, input 1 waits for its tail.
        send(0, 8'hC1, 1'b0, 0);
        send(0, 8'hC2, 1'b1, 0);
        send(1, 8'hD1, 1'b1, 0);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        wait_drain("wrap", 30);

        // Reset while input 2 owns the port mid-packet.
        load(2, 8'h21, 1'b0, 0);
        load(2, 8'h22, 1'b0, 0);
        load(2, 8'h23, 1'b1, 0);
        tick();
        check("t5_grant_pre", grant, 5'b00100);
        check("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_grant_rst", grant, 0);
        check("t5_valid_rst", out_valid, 0);
        check("t5_busy_rst", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(2, 8'h2F, 1'b1, 0);
        exp_grant.push_back(2);
        wait_drain("post_reset", 20);

        // Fresh reset, then all inputs request single-flit packets: rotation 0..4,0.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(0, 8'h50, 1'b1, 0);
        send(1, 8'h51, 1'b1, 0);
        send(2, 8'h52, 1'b1, 0);
        send(3, 8'h53, 1'b1, 0);
        send(4, 8'h54, 1'b1, 0);
        send(0, 8'h55, 1'b1, 0);
        for (int k = 0; k < 6; k++) exp_grant.push_back(k % N);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("rot_grant_%0d", k), grant, gtrace[k]);
        end
        wait_drain("rotate", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
